// File: rtl/aes_pkg.sv
// Shared AES constants and types for the round-key scheduler.
package aes_pkg;

   typedef logic [31:0]  word_t;
   typedef logic [127:0] block_t;

   typedef enum logic [1:0] {IDLE, EMIT, FIN} ks_state_t;

   localparam int NR_AES128 = 10;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Rounds outside 1..10 never reach a register, so they map to zero.
   function automatic word_t rcon_word(input logic [3:0] r);
      word_t w;
      w = '0;
      if (r >= 4'd1 && r <= 4'd10) w = {RCON[r], 24'h000000};
      return w;
   endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// SubWord: forward S-box applied to each byte of a 32-bit word.
module aes_sbox_word
   import aes_pkg::*;
(
   input  logic [31:0] w,
   output logic [31:0] sub_w
);

   assign sub_w = {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 on-the-fly key scheduler, round NR down to 0 with valid/ready output.
// Optional AES_INVKS_FWD_EN adds a mode port for the forward schedule (0 up to NR).
module aes_inv_key_sched
   import aes_pkg::*;
#(
   parameter int NR = NR_AES128
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
`ifdef AES_INVKS_FWD_EN
   input  logic         mode,
`endif
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_round,
   output logic         done
);

   // state | meaning
   // IDLE  | waiting for start
   // EMIT  | rk_out/rk_round presented, advance on each transfer
   // FIN   | done pulse, start ignored

   if (NR != NR_AES128) begin : g_bad_nr
      $error("aes_inv_key_sched: only NR=10 (AES-128) is supported");
   end

   localparam logic [3:0] NR_L = 4'(NR);

   ks_state_t    state_q, state_d;
   logic [127:0] key_q, key_d, key_nxt;
   logic [3:0]   round_q, round_d, round_nxt;
   logic         last;
   word_t        w0, w1, w2, w3, sub_in, sub_out;

`ifdef AES_INVKS_FWD_EN
   logic  fwd_q, fwd_d;
   word_t f0, f1, f2, f3;
`endif

   assign {w0, w1, w2, w3} = key_q;

   // One S-box word serves both directions; only the rotated operand differs.
   always_comb begin
      sub_in = {w3[23:0] ^ w2[23:0], w3[31:24] ^ w2[31:24]};
`ifdef AES_INVKS_FWD_EN
      if (fwd_q) sub_in = {w3[23:0], w3[31:24]};
`endif
   end

   aes_sbox_word u_sbox (
      .w     (sub_in),
      .sub_w (sub_out)
   );

`ifdef AES_INVKS_FWD_EN
   assign f0 = w0 ^ sub_out ^ rcon_word(round_q + 4'd1);
   assign f1 = w1 ^ f0;
   assign f2 = w2 ^ f1;
   assign f3 = w3 ^ f2;
`endif

   always_comb begin
      key_nxt   = {w0 ^ sub_out ^ rcon_word(round_q), w1 ^ w0, w2 ^ w1, w3 ^ w2};
      round_nxt = round_q - 4'd1;
      last      = (round_q == 4'd0);
`ifdef AES_INVKS_FWD_EN
      if (fwd_q) begin
         key_nxt   = {f0, f1, f2, f3};
         round_nxt = round_q + 4'd1;
         last      = (round_q == NR_L);
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      round_d = round_q;
`ifdef AES_INVKS_FWD_EN
      fwd_d   = fwd_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = EMIT;
               key_d   = key_in;
               round_d = NR_L;
`ifdef AES_INVKS_FWD_EN
               fwd_d   = mode;
               if (mode) round_d = 4'd0;
`endif
            end
         end
         EMIT: begin
            if (rk_ready) begin
               if (last) begin
                  state_d = FIN;
               end else begin
                  key_d   = key_nxt;
                  round_d = round_nxt;
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         key_q   <= '0;
         round_q <= '0;
`ifdef AES_INVKS_FWD_EN
         fwd_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         round_q <= round_d;
`ifdef AES_INVKS_FWD_EN
         fwd_q   <= fwd_d;
`endif
      end
   end

   assign busy     = (state_q != IDLE);
   assign rk_valid = (state_q == EMIT);
   assign done     = (state_q == FIN);
   assign rk_out   = key_q;
   assign rk_round = round_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: FIPS-197 key expansion model with a per-cycle compare.
// Forward-mode runs are included when AES_INVKS_FWD_EN is defined.
module tb_aes_inv_key_sched;

   logic         clk = 1'b0;
   logic         rst, start, rk_ready, busy, rk_valid, done;
   logic [127:0] key_in, rk_out;
   logic [3:0]   rk_round;
`ifdef AES_INVKS_FWD_EN
   logic         mode;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aes_inv_key_sched #(.NR(10)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .key_in   (key_in),
`ifdef AES_INVKS_FWD_EN
      .mode     (mode),
`endif
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .rk_out   (rk_out),
      .rk_round (rk_round),
      .done     (done)
   );

   localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   typedef struct packed {
      logic [3:0]   r;
      logic [127:0] k;
   } rk_t;

   logic [7:0]   sb [256];
   logic [127:0] cur_sched [0:10];
   bit           cur_fwd = 1'b0;
   rk_t          m_q [$];
   bit           m_busy = 1'b0, m_done = 1'b0, m_zero = 1'b0, m_live = 1'b0;
   bit           rand_ready = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] x, input int n);
      return 8'((x << n) | (x >> (8 - n)));
   endfunction

   // S-box from first principles: GF(2^8) inverse then the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         sb[a] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   task automatic expand(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++)
         cur_sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Reference: queue of round keys still to be transferred, plus busy/done flags.
   always @(posedge clk) begin
      if (rst) begin
         m_q.delete();
         m_busy = 1'b0;
         m_done = 1'b0;
         m_zero = 1'b1;
         m_live = 1'b1;
      end else if (m_live) begin
         if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
         end else if (m_q.size() != 0) begin
            if (rk_ready) begin
               void'(m_q.pop_front());
               if (m_q.size() == 0) m_done = 1'b1;
            end
         end else if (!m_busy && start) begin
            for (int i = 0; i <= 10; i++)
               if (cur_fwd) m_q.push_back('{r: 4'(i), k: cur_sched[i]});
               else         m_q.push_back('{r: 4'(10 - i), k: cur_sched[10 - i]});
            m_busy = 1'b1;
            m_zero = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         check("busy", busy, m_busy);
         check("rk_valid", rk_valid, m_q.size() != 0);
         check("done", done, m_done);
         if (m_q.size() != 0) begin
            check("rk_out", rk_out, m_q[0].k);
            check("rk_round", rk_round, m_q[0].r);
         end else if (m_zero) begin
            check("rst_rk_out", rk_out, 128'h0);
            check("rst_rk_round", rk_round, 4'h0);
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rand_ready) rk_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [127:0] k, input bit f);
      key_in = k;
      start  = 1'b1;
`ifdef AES_INVKS_FWD_EN
      mode   = f;
`endif
      tick();
      start  = 1'b0;
      key_in = 128'($urandom());
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((busy || rk_valid) && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL idle_timeout: got busy=%0b after %0d cycles expected busy=0", busy, n);
      end
   endtask

   function automatic logic [127:0] rand_key();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; rk_ready = 1'b1; key_in = '0;
`ifdef AES_INVKS_FWD_EN
      mode = 1'b0;
`endif
      build_sbox();
      check("sbox_00", sb[8'h00], 8'h63);
      check("sbox_01", sb[8'h01], 8'h7c);
      check("sbox_53", sb[8'h53], 8'hed);
      expand(FIPS_K0);
      check("model_k10", cur_sched[10], FIPS_K10);
      check("model_k9", cur_sched[9], FIPS_K9);
      check("model_k1", cur_sched[1], FIPS_K1);
      check("model_k0", cur_sched[0], FIPS_K0);
      cur_fwd = 1'b0;

      repeat (3) tick();
      rst = 1'b0;
      tick();

      // FIPS-197 inverse run, one cycle latency to first key
      do_start(FIPS_K10, 1'b0);
      check("lat_valid", rk_valid, 1'b1);
      check("first_key", rk_out, FIPS_K10);
      check("first_round", rk_round, 4'd10);
      wait_idle(40);

      // Backpressure at round 9
      do_start(FIPS_K10, 1'b0);
      tick();
      rk_ready = 1'b0;
      repeat (5) tick();
      check("bp_key", rk_out, FIPS_K9);
      check("bp_round", rk_round, 4'd9);
      rk_ready = 1'b1;
      wait_idle(40);

      // Start while busy, including the done cycle, is ignored
      do_start(FIPS_K10, 1'b0);
      repeat (3) tick();
      do_start(rand_key(), 1'b0);
      n = 0;
      while (!done && n < 40) begin tick(); n++; end
      checks++;
      if (n >= 40) begin errors++; $display("FAIL done_timeout: got done=0 expected done=1"); end
      key_in = rand_key();
      start  = 1'b1;
      tick();
      start  = 1'b0;
      wait_idle(40);
      repeat (4) tick();

      // Reset at round 5, then a fresh run
      do_start(FIPS_K10, 1'b0);
      n = 0;
      while (!(rk_valid && rk_round == 4'd5) && n < 40) begin tick(); n++; end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_valid", rk_valid, 1'b0);
      check("mid_rst_key", rk_out, 128'h0);
      tick();
      do_start(FIPS_K10, 1'b0);
      check("restart_round", rk_round, 4'd10);
      check("restart_key", rk_out, FIPS_K10);
      wait_idle(40);

      // Back-to-back runs
      do_start(FIPS_K10, 1'b0);
      wait_idle(40);
      do_start(FIPS_K10, 1'b0);
      check("b2b_valid", rk_valid, 1'b1);
      wait_idle(40);

      // Random keys with random backpressure and gaps
      rand_ready = 1'b1;
      for (int it = 0; it < 12; it++) begin
         expand(rand_key());
         repeat ($urandom_range(0, 3)) tick();
         do_start(cur_sched[10], 1'b0);
         wait_idle(200);
      end
      rand_ready = 1'b0;
      rk_ready   = 1'b1;
      tick();

`ifdef AES_INVKS_FWD_EN
      expand(FIPS_K0);
      cur_fwd = 1'b1;
      do_start(FIPS_K0, 1'b1);
      check("fwd_k0", rk_out, FIPS_K0);
      tick();
      check("fwd_k1", rk_out, FIPS_K1);
      wait_idle(40);
      rand_ready = 1'b1;
      for (int it = 0; it < 4; it++) begin
         expand(rand_key());
         do_start(cur_sched[0], 1'b1);
         wait_idle(200);
      end
      rand_ready = 1'b0;
      rk_ready   = 1'b1;
      cur_fwd    = 1'b0;
      tick();
`endif

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_inv_key_sched.md
# aes_inv_key_sched

Byte-oriented AES-128 inverse key scheduler: accepts the final round key (round 10) and emits round keys 10 down to 0, one per accepted transfer, with valid/ready backpressure. It feeds the decryption datapath, which pairs it with inverse-mode SubBytes, InvShiftRows and InvMixColumns. Round keys are generated on the fly, so the full key schedule is never stored.

## Interface
Parameters:
- NR, 10: final round index. Only 10 (AES-128) is supported; any other value is an elaboration error.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request. Sampled only while busy=0.
- key_in  in  128  round-NR key, sampled with start. Word w0 is [127:96]; first byte is [127:120].
- mode  in  1  present only with AES_INVKS_FWD_EN. Sampled with start. 0 = inverse, 1 = forward.
- busy  out  1  high from the cycle after start is accepted until done.
- rk_valid  out  1  rk_out and rk_round are valid.
- rk_ready  in  1  consumer accepts the current round key.
- rk_out  out  128  current round key.
- rk_round  out  4  round index of rk_out.
- done  out  1  one-cycle pulse after the last round key transfers.

## Operation
- FSM states:
  - IDLE: accepts start when busy=0.
  - EMIT: presents round keys.
  - FIN: pulses done for one cycle, then returns to IDLE.
- IDLE -> EMIT on start:
  - rk_out <= key_in
  - rk_round <= NR (inverse) or 0 (forward)
  - rk_valid <= 1
- Transfer occurs when rk_valid & rk_ready.
- On a transfer that is not the last, the next round key is registered. Inverse step from round r to r-1, using words w0..w3 of round r:
  - p3 = w3^w2
  - p2 = w2^w1
  - p1 = w1^w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ Rcon[r]
  - rk_round decrements by 1.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, placed in the MS byte of the word.
- RotWord rotates left by one byte. SubWord applies the forward S-box to each of the 4 bytes; the inverse schedule also uses the forward S-box.
- Last transfer is at round 0 (inverse) or round NR (forward). On it: EMIT -> FIN, and rk_valid drops in the next cycle.
- Backpressure: while rk_valid=1 and rk_ready=0, rk_out and rk_round hold stable.
- start while busy=1 is ignored; no queuing. Same-cycle start and done (in FIN) is also ignored.
- rst at any time, mid-sequence included, clears everything in the next cycle:
  - FSM -> IDLE
  - rk_valid, busy, done = 0
  - rk_out = 0, rk_round = 0

## Timing
- Reset values: all outputs 0.
- Start accepted at edge N:
  - busy=1 and rk_valid=1 with round NR from N+1.
- Throughput: one round key per cycle while rk_ready=1. With rk_ready held high, 11 keys are transferred at edges N+1..N+11.
- done is high during cycle N+12, with busy still 1. busy=0 from N+13.
- The key update path is combinational within one cycle: 4 S-box lookups plus XORs. There is no internal pipeline register.

## Configuration
- AES_INVKS_FWD_EN defined:
  - Adds the mode port.
  - mode=1 runs the forward schedule from the cipher key: round 0 up to NR.
  - Forward step from round r to r+1:
    - n0 = w0 ^ SubWord(RotWord(w3)) ^ Rcon[r+1]
    - n1 = w1^n0
    - n2 = w2^n1
    - n3 = w3^n2
    - rk_round increments by 1.
- AES_INVKS_FWD_EN undefined:
  - No mode port; inverse only.
  - Forward logic is not synthesized.

## Structure
- Shared package aes_pkg:
  - word_t (logic [31:0]) and block_t (logic [127:0])
  - SBOX[256] constant
  - RCON[1:10] constant
  - NR_AES128 = 10
- One sub-module, aes_sbox_word: combinational 32-bit SubWord built from 4 SBOX lookups. It is instantiated once and shared by both directions.

## Test plan
- FIPS-197 A.1 inverse, rk_ready=1. start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6 gives, in order:
  - round 10: d014f9a8c9ee2589e13f0cc8b6630ca6
  - round 9: ac7766f319fadc2128d12941575c006e
  - round 1: a0fafe1788542cb123a339392a6c7605
  - round 0: 2b7e151628aed2a6abf7158809cf4f3c
  - done pulses one cycle after the round-0 transfer.
- Backpressure: hold rk_ready=0 for 5 cycles at round 9 -> rk_out stays ac7766f3…006e with rk_round=9, then the sequence resumes unchanged.
- Ignored start: assert start with a different key while busy -> the output sequence is unaffected and no extra done pulse occurs.
- Reset mid-sequence: assert rst while rk_round=5 -> next cycle all outputs are 0. A fresh start then produces round 10 correctly.
- Back-to-back runs: start again on the cycle after busy falls -> the identical 11-key sequence repeats. Latency is 1 cycle from start to the first rk_valid.
- Forward mode (AES_INVKS_FWD_EN, mode=1). key_in=2b7e151628aed2a6abf7158809cf4f3c gives, in order:
  - round 0: 2b7e151628aed2a6abf7158809cf4f3c
  - round 1: a0fafe1788542cb123a339392a6c7605
  - round 10: d014f9a8c9ee2589e13f0cc8b6630ca6
